wb_decoder_1m_ns: RTL
=====================

# wb_decoder_1m_ns

Parametrised single-master, N-slave Wishbone (classic, single transfer) address decoder and response multiplexer, the successor to the fixed two-slave arbiter between the ao68000 core and its RAM/UART slaves. It decodes a configurable address field to one of NSLAVES slaves and registers the slave response back to the master. It returns a bus error for unmapped addresses and for slaves that never respond. Target: m68k SoC tops with RAM, UART and further peripherals.

## Interface
- NSLAVES, 4: number of slaves (1..16).
- ADDR_W, 32: address width.
- DATA_W, 32: data width; SEL_W = DATA_W/8.
- DEC_LO, 28: LSB of the decode field; field is m_addr_i[DEC_LO+3:DEC_LO] (4 bits).
- TIMEOUT, 255: watchdog limit in cycles (2..65535).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- m_addr_i  in  ADDR_W  master address.
- m_data_i  in  DATA_W  master write data.
- m_sel_i  in  SEL_W  byte selects.
- m_we_i, m_cyc_i, m_stb_i  in  1 each  master controls.
- m_data_o  out  DATA_W  registered read data.
- m_ack_o, m_err_o, m_rty_o  out  1 each  registered responses.
- s_addr_o  out  ADDR_W  broadcast address; decode field forced to 0.
- s_data_o  out  DATA_W  broadcast write data.
- s_sel_o  out  SEL_W  broadcast byte selects.
- s_we_o  out  1  broadcast write enable.
- s_cyc_o, s_stb_o  out  NSLAVES  one-hot per-slave cyc/stb.
- s_data_i  in  NSLAVES*DATA_W  slave read data; slave k at [k*DATA_W +: DATA_W].
- s_ack_i, s_err_i, s_rty_i  in  NSLAVES  slave responses.

## Operation
- FSM states IDLE, ACTIVE, RESP.
- IDLE: on m_cyc_i & m_stb_i, latch idx = decode field, plus addr/data/sel/we.
  - idx < NSLAVES: go to ACTIVE.
  - idx >= NSLAVES: go to RESP with err.
- ACTIVE: s_cyc_o[idx] = s_stb_o[idx] = 1, all other bits 0. Broadcast outputs come from the latched request.
  - Response priority: err > rty > ack.
  - On a response, capture the response type and s_data_i[idx] into m_data_o, then go to RESP.
- RESP: exactly one of m_ack_o/m_err_o/m_rty_o high for one cycle; slave cyc/stb low; then go to IDLE.
- m_data_o updates only on a captured ack with !we. It holds its value otherwise, and is 0 after unmapped or timeout errors.
- Master abort: m_cyc_i low in ACTIVE drops slave cyc/stb the same cycle (combinational gate), returns to IDLE next edge, and produces no response.
- Watchdog: counter cleared on entry to ACTIVE, increments each ACTIVE cycle. At count == TIMEOUT-1 with no response, go to RESP with err. A slave response in that same cycle wins over the timeout.
- Responses from non-selected slaves are ignored.

## Timing
- Reset values: all m_* outputs 0, s_cyc_o/s_stb_o 0, s_addr_o/s_data_o/s_sel_o/s_we_o 0, FSM in IDLE, counter 0.
- Request sampled at edge 0; slave stb visible in cycle 1.
- Zero-wait slave (acks in cycle 1): m_ack_o in cycle 2, a 3-cycle transfer.
- Each slave wait state adds one cycle.
- Unmapped address: m_err_o in cycle 1.
- Timeout: m_err_o in cycle TIMEOUT+1.
- Back-to-back: a new request is sampled in the IDLE cycle after RESP.
- m_stb_i low in IDLE: no action, regardless of m_cyc_i.
- Reset mid-transfer: everything returns to reset values immediately, with no response issued.

## Configuration
- WB_DEC_TIMEOUT_EN defined: watchdog counter present, behaving as above.
- Undefined: no counter; ACTIVE waits indefinitely for the slave or a master abort. The TIMEOUT parameter is unused.
- Unmapped-address err is generated in both builds.

## Test plan
- Read 0x1000_0004, slave 1 acks in cycle 1 with 0xDEADBEEF: s_stb_o=4'b0010 and s_addr_o=0x0000_0004 in cycle 1; m_ack_o and m_data_o=0xDEADBEEF in cycle 2.
- Write 0x0000_0010, data 0x12345678, sel 4'b0011; slave 0 waits 3 cycles: s_data_o/s_sel_o stable; m_ack_o in cycle 5; m_data_o unchanged.
- Access 0x5000_0000 (NSLAVES=4): m_err_o in cycle 1; no s_stb_o bit ever set.
- WB_DEC_TIMEOUT_EN defined, TIMEOUT=16, slave 2 silent: m_err_o in cycle 17, s_stb_o low from then on. Repeat with the ack in cycle 16: m_ack_o, not m_err_o.
- Slave 3 asserts err and ack together: m_err_o only. Then drop m_cyc_i mid-ACTIVE on a new request: s_stb_o low the same cycle, no response.
- Assert rst_ni low during ACTIVE: all outputs 0 asynchronously. After release, a fresh access to slave 0 completes normally.

Source files
------------

// File: rtl/wb_decoder_1m_ns.sv
// Single-master, N-slave Wishbone classic decoder with registered response path.
// Optional slave watchdog enabled by defining WB_DEC_TIMEOUT_EN.
module wb_decoder_1m_ns #(
  parameter int NSLAVES = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEC_LO  = 28,
  parameter int TIMEOUT = 255,
  localparam int SEL_W  = DATA_W / 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [ADDR_W-1:0]         m_addr_i,
  input  logic [DATA_W-1:0]         m_data_i,
  input  logic [SEL_W-1:0]          m_sel_i,
  input  logic                      m_we_i,
  input  logic                      m_cyc_i,
  input  logic                      m_stb_i,
  output logic [DATA_W-1:0]         m_data_o,
  output logic                      m_ack_o,
  output logic                      m_err_o,
  output logic                      m_rty_o,
  output logic [ADDR_W-1:0]         s_addr_o,
  output logic [DATA_W-1:0]         s_data_o,
  output logic [SEL_W-1:0]          s_sel_o,
  output logic                      s_we_o,
  output logic [NSLAVES-1:0]        s_cyc_o,
  output logic [NSLAVES-1:0]        s_stb_o,
  input  logic [NSLAVES*DATA_W-1:0] s_data_i,
  input  logic [NSLAVES-1:0]        s_ack_i,
  input  logic [NSLAVES-1:0]        s_err_i,
  input  logic [NSLAVES-1:0]        s_rty_i
);

  typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_t;

  localparam logic [ADDR_W-1:0] DEC_MASK = ~({{(ADDR_W-4){1'b0}}, 4'hF} << DEC_LO);

  state_t              state_reg;
  logic [3:0]          idx_reg;
  logic [NSLAVES-1:0]  sel_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [SEL_W-1:0]    be_reg;
  logic                we_reg;

  logic [3:0]          dec_idx;
  logic                dec_hit;
  logic [NSLAVES-1:0]  dec_onehot;

  // Slave responses padded to the full 16-entry decode space so the latched
  // 4-bit index can select them directly.
  logic [15:0]         ack_pad;
  logic [15:0]         err_pad;
  logic [15:0]         rty_pad;
  logic [DATA_W-1:0]   rdata_pad [16];

  assign dec_idx = m_addr_i[DEC_LO+3:DEC_LO];
  assign dec_hit = (int'(dec_idx) < NSLAVES);

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_pad
      if (gi < NSLAVES) begin : g_live
        assign ack_pad[gi]    = s_ack_i[gi];
        assign err_pad[gi]    = s_err_i[gi];
        assign rty_pad[gi]    = s_rty_i[gi];
        assign rdata_pad[gi]  = s_data_i[gi*DATA_W +: DATA_W];
        assign dec_onehot[gi] = (dec_idx == 4'(gi));
      end else begin : g_dead
        assign ack_pad[gi]    = 1'b0;
        assign err_pad[gi]    = 1'b0;
        assign rty_pad[gi]    = 1'b0;
        assign rdata_pad[gi]  = '0;
      end
    end
  endgenerate

  logic              sl_ack;
  logic              sl_err;
  logic              sl_rty;
  logic [DATA_W-1:0] sl_data;

  assign sl_ack  = ack_pad[idx_reg];
  assign sl_err  = err_pad[idx_reg];
  assign sl_rty  = rty_pad[idx_reg];
  assign sl_data = rdata_pad[idx_reg];

  // Dropping m_cyc_i must release the slave in the same cycle, hence the gate.
  assign s_cyc_o  = sel_reg & {NSLAVES{m_cyc_i}};
  assign s_stb_o  = sel_reg & {NSLAVES{m_cyc_i}};
  assign s_addr_o = addr_reg;
  assign s_data_o = wdata_reg;
  assign s_sel_o  = be_reg;
  assign s_we_o   = we_reg;

  logic wdog_expired;

`ifdef WB_DEC_TIMEOUT_EN
  logic [15:0] wdog_reg;

  assign wdog_expired = (wdog_reg == 16'(TIMEOUT - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wdog_reg <= '0;
    end else if (state_reg == ACTIVE) begin
      wdog_reg <= wdog_reg + 16'd1;
    end else begin
      wdog_reg <= '0;
    end
  end
`else
  assign wdog_expired = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      sel_reg   <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      be_reg    <= '0;
      we_reg    <= 1'b0;
      m_data_o  <= '0;
      m_ack_o   <= 1'b0;
      m_err_o   <= 1'b0;
      m_rty_o   <= 1'b0;
    end else begin
      m_ack_o <= 1'b0;
      m_err_o <= 1'b0;
      m_rty_o <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (m_cyc_i && m_stb_i) begin
            idx_reg   <= dec_idx;
            addr_reg  <= m_addr_i & DEC_MASK;
            wdata_reg <= m_data_i;
            be_reg    <= m_sel_i;
            we_reg    <= m_we_i;
            if (dec_hit) begin
              state_reg <= ACTIVE;
              sel_reg   <= dec_onehot;
            end else begin
              state_reg <= RESP;
              m_err_o   <= 1'b1;
              m_data_o  <= '0;
            end
          end
        end
        ACTIVE: begin
          if (!m_cyc_i) begin
            state_reg <= IDLE;
            sel_reg   <= '0;
          end else if (sl_err) begin
            state_reg <= RESP;
            sel_reg   <= '0;
            m_err_o   <= 1'b1;
          end else if (sl_rty) begin
            state_reg <= RESP;
            sel_reg   <= '0;
            m_rty_o   <= 1'b1;
          end else if (sl_ack) begin
            state_reg <= RESP;
            sel_reg   <= '0;
            m_ack_o   <= 1'b1;
            if (!we_reg) begin
              m_data_o <= sl_data;
            end
          end else if (wdog_expired) begin
            state_reg <= RESP;
            sel_reg   <= '0;
            m_err_o   <= 1'b1;
            m_data_o  <= '0;
          end
        end
        RESP: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          sel_reg   <= '0;
        end
      endcase
    end
  end

endmodule
